hmnoc_cluster_seq: RTL and testbench
====================================

# hmnoc_cluster_seq

Multi-cluster sequencer for the hierarchical mesh NoC. Replaces the testbench-driven control of a single GLB/router/PE cluster with an on-chip FSM. The FSM drives NUM_CLUSTERS cluster instances through repeated passes of weight spad load, iact spad load, compute and psum writeback. It sits above the cluster instances: it drives their load_spad_ctrl_* and start inputs and collects their load_done and compute_done outputs.

## Interface
- NUM_CLUSTERS, 4: number of cluster instances controlled (1..16).
- PASS_BITWIDTH, 8: width of the pass counter and cfg_passes.
- WB_CYCLES, 9: cycles allowed for psum-router writeback after compute_done (default kernel_size*kernel_size, i.e. 9 for kernel_size=3).
- TIMEOUT_CYCLES, 1024: watchdog limit per wait state; must be ≥2.
- clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low; when low at a rising edge all state returns to reset values.
- start  in  1  single-cycle request; accepted only in IDLE.
- abort  in  1  forces return to IDLE from any state.
- cfg_passes  in  PASS_BITWIDTH  number of passes; sampled at start.
- cfg_cluster_en  in  NUM_CLUSTERS  enabled-cluster mask; sampled at start.
- cfg_wght_reuse  in  1  1 = load weights on pass 0 only; sampled at start.
- load_spad_ctrl_wght  out  NUM_CLUSTERS  one-cycle weight-load pulse per enabled cluster.
- load_spad_ctrl_iact  out  NUM_CLUSTERS  one-cycle iact-load pulse per enabled cluster.
- pe_start  out  NUM_CLUSTERS  one-cycle compute-start pulse per enabled cluster.
- pe_load_done  in  NUM_CLUSTERS  per-cluster load completion (pulse or level).
- pe_compute_done  in  NUM_CLUSTERS  per-cluster compute completion (pulse or level).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last pass completes.
- err_cfg  out  1  one-cycle pulse when start is rejected.
- err_timeout  out  1  sticky timeout flag; cleared by the next accepted start or by reset.
- pass_idx  out  PASS_BITWIDTH  index of the current pass.

## Operation
- States: IDLE, LD_WGHT, LD_IACT, WAIT_LOAD, COMPUTE, WAIT_COMP, WRITEBACK, NEXT.
- IDLE:
  - start with cfg_passes==0 or cfg_cluster_en==0 → err_cfg pulse, stay in IDLE.
  - Otherwise latch the cfg inputs, clear pass_idx and err_timeout, and go to LD_WGHT.
- LD_WGHT: pulse load_spad_ctrl_wght on the latched mask, then go to LD_IACT. The state is skipped (LD_IACT entered directly) when cfg_wght_reuse=1 and pass_idx≠0.
- LD_IACT: pulse load_spad_ctrl_iact on the latched mask, clear the load_seen register, go to WAIT_LOAD.
- WAIT_LOAD:
  - load_seen |= pe_load_done & mask.
  - When all masked bits are set, go to COMPUTE.
- COMPUTE: pulse pe_start on the mask, clear comp_seen, go to WAIT_COMP.
- WAIT_COMP: comp_seen |= pe_compute_done & mask; when all masked bits are set, go to WRITEBACK.
- WRITEBACK: count WB_CYCLES cycles, then go to NEXT.
- NEXT:
  - If pass_idx == cfg_passes-1: pulse done, go to IDLE.
  - Otherwise increment pass_idx and go to LD_WGHT.
- Done inputs from disabled clusters are ignored.
- A done input that arrives in the same cycle the seen register is cleared is lost. Clusters must not assert done before the corresponding pulse.
- Watchdog:
  - Counts cycles spent in WAIT_LOAD or WAIT_COMP and resets on each entry to those states.
  - On reaching TIMEOUT_CYCLES: set err_timeout and go to IDLE; done does not pulse.
- abort has priority over every transition: go to IDLE, drop all pulses that cycle, no done.
- start while busy is ignored and does not pulse err_cfg.
- reset has priority over abort.

## Timing
- Reset values: all pulse outputs 0, busy 0, done 0, err_cfg 0, err_timeout 0, pass_idx 0, state IDLE.
- Outputs are registered. Each pulse is high for exactly the one cycle the FSM spends in its state.
- Start accepted at edge N:
  - busy rises at N+1.
  - load_spad_ctrl_wght high in cycle N+1.
  - load_spad_ctrl_iact high in cycle N+2.
- Loads seen complete at edge M: pe_start high in cycle M+1.
- Compute seen complete at edge K: WRITEBACK occupies K+2 .. K+1+WB_CYCLES, and NEXT follows.
- done and busy-fall occur in the same cycle.
- A new start is accepted in the cycle after done.

## Structure
- Package hmnoc_pkg: state enum hmnoc_seq_state_t and a localparam for the default WB_CYCLES, derived from kernel_size.
- Sub-module hmnoc_done_collector (parameter NUM_CLUSTERS):
  - Sticky OR with clear and mask, all_done output.
  - Instantiated twice, once for loads and once for compute.

## Test plan
- NUM_CLUSTERS=4, mask=4'b1111, passes=2, reuse=0, each cluster acknowledges 3 cycles after each pulse → two wght pulses, two iact pulses, two pe_start pulses, done once, pass_idx goes 0→1.
- reuse=1, passes=3 → load_spad_ctrl_wght pulses only once; iact and pe_start each pulse 3 times.
- mask=4'b0101, pe_load_done returns staggered (cluster0 at +2, cluster2 at +7), clusters 1 and 3 silent → pe_start 4'b0101 in the cycle after cluster2's ack.
- TIMEOUT_CYCLES=16, cluster 2 never asserts compute_done → err_timeout set after 16 cycles in WAIT_COMP, busy falls, no done. A following valid start clears err_timeout.
- Edge cases:
  - start with passes=0 → err_cfg pulse, busy stays 0.
  - abort during WRITEBACK → IDLE the next cycle, no done.
  - reset low during WAIT_LOAD → all outputs 0 the next cycle.
- start re-asserted while busy → ignored; exactly one done at the end.

Source files
------------

// File: rtl/hmnoc_pkg.sv
// Shared definitions for the hierarchical-mesh NoC cluster sequencer.
//
// Contents:
//   KERNEL_SIZE / WB_CYCLES_DEFAULT : psum writeback window derived from the
//                                     convolution kernel size.
//   ST_*                            : legacy-compatible FSM state encodings.
//   hmnoc_seq_state_t               : typed view of the same encodings.
package hmnoc_pkg;

    localparam int KERNEL_SIZE       = 3;
    // The psum router drains one kernel window per writeback pass.
    localparam int WB_CYCLES_DEFAULT = KERNEL_SIZE * KERNEL_SIZE;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LD_WGHT   = 3'd1;
    localparam logic [2:0] ST_LD_IACT   = 3'd2;
    localparam logic [2:0] ST_WAIT_LOAD = 3'd3;
    localparam logic [2:0] ST_COMPUTE   = 3'd4;
    localparam logic [2:0] ST_WAIT_COMP = 3'd5;
    localparam logic [2:0] ST_WRITEBACK = 3'd6;
    localparam logic [2:0] ST_NEXT      = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_LD_WGHT   = ST_LD_WGHT,
        S_LD_IACT   = ST_LD_IACT,
        S_WAIT_LOAD = ST_WAIT_LOAD,
        S_COMPUTE   = ST_COMPUTE,
        S_WAIT_COMP = ST_WAIT_COMP,
        S_WRITEBACK = ST_WRITEBACK,
        S_NEXT      = ST_NEXT
    } hmnoc_seq_state_t;

endpackage

// File: rtl/hmnoc_cluster_seq_if.sv
// Sequencer <-> cluster array bundle.
//
// Signals (one bit per cluster):
//   load_spad_ctrl_wght : weight spad load pulse      (sequencer -> cluster)
//   load_spad_ctrl_iact : iact spad load pulse        (sequencer -> cluster)
//   pe_start            : compute start pulse         (sequencer -> cluster)
//   pe_load_done        : load completion, pulse/level (cluster -> sequencer)
//   pe_compute_done     : compute completion          (cluster -> sequencer)
// Modports: master = sequencer side, slave = cluster side.
interface hmnoc_cluster_seq_if #(
    parameter int NUM_CLUSTERS = 4
);
    import hmnoc_pkg::*;

    logic [NUM_CLUSTERS-1:0] load_spad_ctrl_wght;
    logic [NUM_CLUSTERS-1:0] load_spad_ctrl_iact;
    logic [NUM_CLUSTERS-1:0] pe_start;
    logic [NUM_CLUSTERS-1:0] pe_load_done;
    logic [NUM_CLUSTERS-1:0] pe_compute_done;

    modport master (
        output load_spad_ctrl_wght,
        output load_spad_ctrl_iact,
        output pe_start,
        input  pe_load_done,
        input  pe_compute_done
    );

    modport slave (
        input  load_spad_ctrl_wght,
        input  load_spad_ctrl_iact,
        input  pe_start,
        output pe_load_done,
        output pe_compute_done
    );

endinterface

// File: rtl/hmnoc_done_collector.sv
// Per-cluster completion collector.
//
// Accumulates done inputs of enabled clusters into a sticky register and
// reports when every enabled cluster has been seen.
//
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   clr        : clear the seen register (an input arriving this cycle is lost)
//   en         : accumulate done_in this cycle
//   mask       : enabled-cluster mask; disabled clusters are ignored
//   done_in    : per-cluster completion inputs (pulse or level)
//   all_done   : every masked cluster has completed
//
// QUALIFY_REG selects whether all_done includes the current-cycle inputs
// (0) or only what has already been captured in the seen register (1).
module hmnoc_done_collector
    import hmnoc_pkg::*;
#(
    parameter int NUM_CLUSTERS = 4,
    parameter bit QUALIFY_REG  = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    en,
    input  logic [NUM_CLUSTERS-1:0] mask,
    input  logic [NUM_CLUSTERS-1:0] done_in,
    output logic                    all_done
);

    logic [NUM_CLUSTERS-1:0] seen_q;
    logic [NUM_CLUSTERS-1:0] hit;

    assign hit = en ? (seen_q | (done_in & mask)) : seen_q;

    // Disabled clusters read as complete so only the mask decides.
    generate
        if (QUALIFY_REG) begin : g_reg
            assign all_done = &(seen_q | ~mask);
        end else begin : g_comb
            assign all_done = &(hit | ~mask);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            seen_q <= '0;
        end else if (clr) begin
            seen_q <= '0;
        end else if (en) begin
            seen_q <= hit;
        end
    end

endmodule

// File: rtl/hmnoc_cluster_seq.sv
// Multi-cluster sequencer for the hierarchical mesh NoC.
//
// Drives NUM_CLUSTERS GLB/router/PE clusters through repeated passes of
// weight spad load, iact spad load, compute and psum writeback.
//
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   start           : single-cycle run request (accepted only when idle)
//   abort           : return to idle from any state
//   cfg_passes      : number of passes (sampled at start)
//   cfg_cluster_en  : enabled-cluster mask (sampled at start)
//   cfg_wght_reuse  : load weights on pass 0 only (sampled at start)
//   cl              : cluster bundle (load/start pulses out, done flags in)
//   busy            : high whenever not idle
//   done            : one-cycle pulse after the last pass
//   err_cfg         : one-cycle pulse when a start is rejected
//   err_timeout     : sticky watchdog flag, cleared by the next accepted start
//   pass_idx        : index of the current pass
//
// All outputs are registered: each is computed from the next state so that
// a pulse is high exactly during the cycle the FSM spends in its state.
module hmnoc_cluster_seq
    import hmnoc_pkg::*;
#(
    parameter int NUM_CLUSTERS   = 4,
    parameter int PASS_BITWIDTH  = 8,
    parameter int WB_CYCLES      = WB_CYCLES_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [PASS_BITWIDTH-1:0] cfg_passes,
    input  logic [NUM_CLUSTERS-1:0]  cfg_cluster_en,
    input  logic                     cfg_wght_reuse,
    hmnoc_cluster_seq_if.master      cl,
    output logic                     busy,
    output logic                     done,
    output logic                     err_cfg,
    output logic                     err_timeout,
    output logic [PASS_BITWIDTH-1:0] pass_idx
);

    // One counter serves both the watchdog and the writeback window; it
    // restarts on every state change, which covers "reset on entry".
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + WB_CYCLES + 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WB_LAST = CNT_W'(WB_CYCLES - 1);

    hmnoc_seq_state_t          state_q, state_n;
    logic [NUM_CLUSTERS-1:0]   mask_q, mask_n;
    logic [PASS_BITWIDTH-1:0]  passes_q, passes_n;
    logic                      reuse_q, reuse_n;
    logic [PASS_BITWIDTH-1:0]  pass_n;
    logic [CNT_W-1:0]          cnt_q;

    logic                      done_n;
    logic                      err_cfg_n;
    logic                      to_set;
    logic                      to_clr;

    logic [NUM_CLUSTERS-1:0]   wght_q;
    logic [NUM_CLUSTERS-1:0]   iact_q;
    logic [NUM_CLUSTERS-1:0]   pe_start_q;

    logic                      ld_all;
    logic                      cp_all;

    assign cl.load_spad_ctrl_wght = wght_q;
    assign cl.load_spad_ctrl_iact = iact_q;
    assign cl.pe_start            = pe_start_q;

    // Load completion is taken from the live inputs so pe_start follows the
    // last acknowledge by one cycle.
    hmnoc_done_collector #(
        .NUM_CLUSTERS (NUM_CLUSTERS),
        .QUALIFY_REG  (1'b0)
    ) u_load_done (
        .clk      (clk),
        .reset    (reset),
        .clr      (state_q == S_LD_IACT),
        .en       (state_q == S_WAIT_LOAD),
        .mask     (mask_q),
        .done_in  (cl.pe_load_done),
        .all_done (ld_all)
    );

    // Compute completion is qualified on the captured seen vector, giving
    // the psum path one settle cycle before writeback starts.
    hmnoc_done_collector #(
        .NUM_CLUSTERS (NUM_CLUSTERS),
        .QUALIFY_REG  (1'b1)
    ) u_comp_done (
        .clk      (clk),
        .reset    (reset),
        .clr      (state_q == S_COMPUTE),
        .en       (state_q == S_WAIT_COMP),
        .mask     (mask_q),
        .done_in  (cl.pe_compute_done),
        .all_done (cp_all)
    );

    always_comb begin
        state_n   = state_q;
        mask_n    = mask_q;
        passes_n  = passes_q;
        reuse_n   = reuse_q;
        pass_n    = pass_idx;
        done_n    = 1'b0;
        err_cfg_n = 1'b0;
        to_set    = 1'b0;
        to_clr    = 1'b0;

        if (abort) begin
            state_n = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_passes == '0 || cfg_cluster_en == '0) begin
                            err_cfg_n = 1'b1;
                        end else begin
                            mask_n   = cfg_cluster_en;
                            passes_n = cfg_passes;
                            reuse_n  = cfg_wght_reuse;
                            pass_n   = '0;
                            to_clr   = 1'b1;
                            state_n  = S_LD_WGHT;
                        end
                    end
                end
                S_LD_WGHT: state_n = S_LD_IACT;
                S_LD_IACT: state_n = S_WAIT_LOAD;
                S_WAIT_LOAD: begin
                    if (ld_all) begin
                        state_n = S_COMPUTE;
                    end else if (cnt_q == WD_LAST) begin
                        to_set  = 1'b1;
                        state_n = S_IDLE;
                    end
                end
                S_COMPUTE: state_n = S_WAIT_COMP;
                S_WAIT_COMP: begin
                    if (cp_all) begin
                        state_n = S_WRITEBACK;
                    end else if (cnt_q == WD_LAST) begin
                        to_set  = 1'b1;
                        state_n = S_IDLE;
                    end
                end
                S_WRITEBACK: begin
                    if (cnt_q == WB_LAST) begin
                        state_n = S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (pass_idx == passes_q - PASS_BITWIDTH'(1)) begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        pass_n  = pass_idx + PASS_BITWIDTH'(1);
                        // Pass index is non-zero here, so reuse skips weights.
                        state_n = reuse_q ? S_LD_IACT : S_LD_WGHT;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            passes_q    <= '0;
            reuse_q     <= 1'b0;
            pass_idx    <= '0;
            cnt_q       <= '0;
            wght_q      <= '0;
            iact_q      <= '0;
            pe_start_q  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_cfg     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_q    <= state_n;
            mask_q     <= mask_n;
            passes_q   <= passes_n;
            reuse_q    <= reuse_n;
            pass_idx   <= pass_n;
            cnt_q      <= (state_n != state_q || state_q == S_IDLE) ? '0 : cnt_q + CNT_W'(1);
            wght_q     <= (state_n == S_LD_WGHT) ? mask_n : '0;
            iact_q     <= (state_n == S_LD_IACT) ? mask_n : '0;
            pe_start_q <= (state_n == S_COMPUTE) ? mask_n : '0;
            busy       <= (state_n != S_IDLE);
            done       <= done_n;
            err_cfg    <= err_cfg_n;
            if (to_clr) begin
                err_timeout <= 1'b0;
            end else if (to_set) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hmnoc_cluster_seq.sv
module tb_hmnoc_cluster_seq;

    localparam int NC = 4;
    localparam int PW = 8;
    localparam int WB = 9;
    localparam int TO = 16;

    localparam logic [3:0] K_W = 4'd1;
    localparam logic [3:0] K_I = 4'd2;
    localparam logic [3:0] K_P = 4'd3;
    localparam logic [3:0] K_D = 4'd4;
    localparam logic [3:0] K_E = 4'd5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [PW-1:0] cfg_passes = '0;
    logic [NC-1:0] cfg_cluster_en = '0;
    logic          cfg_wght_reuse = 1'b0;
    logic          busy, done, err_cfg, err_timeout;
    logic [PW-1:0] pass_idx;

    always #5 clk = ~clk;

    hmnoc_cluster_seq_if #(.NUM_CLUSTERS(NC)) cif ();

    hmnoc_cluster_seq #(
        .NUM_CLUSTERS   (NC),
        .PASS_BITWIDTH  (PW),
        .WB_CYCLES      (WB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .cfg_passes     (cfg_passes),
        .cfg_cluster_en (cfg_cluster_en),
        .cfg_wght_reuse (cfg_wght_reuse),
        .cl             (cif),
        .busy           (busy),
        .done           (done),
        .err_cfg        (err_cfg),
        .err_timeout    (err_timeout),
        .pass_idx       (pass_idx)
    );

    // Cluster model: acknowledge ld_dly/cp_dly cycles after the pulse,
    // a delay of 0 means the cluster stays silent.
    int ld_dly [NC];
    int cp_dly [NC];
    int ld_cnt [NC];
    int cp_cnt [NC];

    always @(negedge clk) begin
        for (int i = 0; i < NC; i++) begin
            cif.pe_load_done[i]    = 1'b0;
            cif.pe_compute_done[i] = 1'b0;
            if (!reset) begin
                ld_cnt[i] = 0;
                cp_cnt[i] = 0;
            end else begin
                if (cif.load_spad_ctrl_iact[i] && ld_dly[i] > 0) begin
                    ld_cnt[i] = ld_dly[i];
                end else if (ld_cnt[i] > 0) begin
                    ld_cnt[i] = ld_cnt[i] - 1;
                    if (ld_cnt[i] == 0) cif.pe_load_done[i] = 1'b1;
                end
                if (cif.pe_start[i] && cp_dly[i] > 0) begin
                    cp_cnt[i] = cp_dly[i];
                end else if (cp_cnt[i] > 0) begin
                    cp_cnt[i] = cp_cnt[i] - 1;
                    if (cp_cnt[i] == 0) cif.pe_compute_done[i] = 1'b1;
                end
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_pe_cyc = 0;
    int done_cnt = 0;
    int wght_cnt = 0;
    int iact_cnt = 0;
    int pe_cnt = 0;
    logic [7:0] sb_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pulse(input logic [3:0] kind, input logic [3:0] val);
        logic [7:0] exp;
        if (sb_q.size() == 0) begin
            check("sb_unexpected_pulse", {24'd0, kind, val}, 32'd0);
        end else begin
            exp = sb_q.pop_front();
            check("sb_pulse", {24'd0, kind, val}, {24'd0, exp});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cif.load_spad_ctrl_wght != '0) begin
            wght_cnt++;
            sb_pulse(K_W, cif.load_spad_ctrl_wght);
        end
        if (cif.load_spad_ctrl_iact != '0) begin
            iact_cnt++;
            sb_pulse(K_I, cif.load_spad_ctrl_iact);
        end
        if (cif.pe_start != '0) begin
            pe_cnt++;
            last_pe_cyc = cyc;
            sb_pulse(K_P, cif.pe_start);
        end
        if (done) begin
            done_cnt++;
            sb_pulse(K_D, 4'h1);
        end
        if (err_cfg) sb_pulse(K_E, 4'h1);
    endtask

    task automatic push(input logic [3:0] kind, input logic [3:0] val);
        sb_q.push_back({kind, val});
    endtask

    task automatic push_pass(input logic wght, input logic [3:0] m);
        if (wght) push(K_W, m);
        push(K_I, m);
        push(K_P, m);
    endtask

    task automatic clr_counts();
        tick();
        done_cnt = 0;
        wght_cnt = 0;
        iact_cnt = 0;
        pe_cnt = 0;
    endtask

    task automatic set_dly(input int l0, input int l1, input int l2, input int l3,
                           input int c0, input int c1, input int c2, input int c3);
        ld_dly[0] = l0; ld_dly[1] = l1; ld_dly[2] = l2; ld_dly[3] = l3;
        cp_dly[0] = c0; cp_dly[1] = c1; cp_dly[2] = c2; cp_dly[3] = c3;
    endtask

    task automatic do_start(input logic [PW-1:0] p, input logic [NC-1:0] m, input logic r);
        cfg_passes = p;
        cfg_cluster_en = m;
        cfg_wght_reuse = r;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_idle(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < budget);
        check("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_pe(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (cif.pe_start == '0 && n < budget);
        check("pe_start_seen", {31'd0, (cif.pe_start != '0)}, 32'd1);
    endtask

    initial begin
        int iact_cyc;
        int pe_cyc;
        set_dly(3, 3, 3, 3, 3, 3, 3, 3);

        // Reset state
        reset = 1'b0;
        repeat (3) tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err_cfg", {31'd0, err_cfg}, 32'd0);
        check("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
        check("rst_pass_idx", {24'd0, pass_idx}, 32'd0);
        check("rst_pulses", {20'd0, cif.load_spad_ctrl_wght, cif.load_spad_ctrl_iact, cif.pe_start}, 32'd0);
        reset = 1'b1;
        tick();

        // Two passes, full mask, no reuse
        clr_counts();
        push_pass(1'b1, 4'hF);
        push_pass(1'b1, 4'hF);
        push(K_D, 4'h1);
        do_start(8'd2, 4'hF, 1'b0);
        check("s1_busy_rise", {31'd0, busy}, 32'd1);
        check("s1_wght_n1", {28'd0, cif.load_spad_ctrl_wght}, 32'hF);
        check("s1_pass0", {24'd0, pass_idx}, 32'd0);
        tick();
        check("s1_iact_n2", {28'd0, cif.load_spad_ctrl_iact}, 32'hF);
        run_to_idle(200);
        check("s1_done_with_busy_fall", {31'd0, done}, 32'd1);
        check("s1_pass_idx_final", {24'd0, pass_idx}, 32'd1);
        check("s1_pe_to_done", cyc - last_pe_cyc, 32'd15);
        check("s1_wght_cnt", wght_cnt, 32'd2);
        check("s1_pe_cnt", pe_cnt, 32'd2);
        check("s1_done_cnt", done_cnt, 32'd1);
        check("s1_sb_drained", sb_q.size(), 32'd0);

        // Weight reuse, three passes
        clr_counts();
        push_pass(1'b1, 4'hF);
        push_pass(1'b0, 4'hF);
        push_pass(1'b0, 4'hF);
        push(K_D, 4'h1);
        do_start(8'd3, 4'hF, 1'b1);
        run_to_idle(300);
        check("s2_wght_cnt", wght_cnt, 32'd1);
        check("s2_iact_cnt", iact_cnt, 32'd3);
        check("s2_pe_cnt", pe_cnt, 32'd3);
        check("s2_done_cnt", done_cnt, 32'd1);
        check("s2_pass_idx_final", {24'd0, pass_idx}, 32'd2);
        check("s2_sb_drained", sb_q.size(), 32'd0);

        // Sparse mask, staggered load acknowledges
        clr_counts();
        set_dly(2, 0, 7, 0, 3, 0, 3, 0);
        push_pass(1'b1, 4'h5);
        push(K_D, 4'h1);
        do_start(8'd1, 4'h5, 1'b0);
        tick();
        iact_cyc = cyc;
        run_to_idle(200);
        check("s3_pe_after_last_ack", last_pe_cyc - iact_cyc, 32'd8);
        check("s3_done_cnt", done_cnt, 32'd1);
        check("s3_sb_drained", sb_q.size(), 32'd0);

        // Watchdog: cluster 2 never finishes compute
        clr_counts();
        set_dly(3, 3, 3, 3, 3, 3, 0, 3);
        push_pass(1'b1, 4'hF);
        do_start(8'd1, 4'hF, 1'b0);
        wait_pe(50);
        pe_cyc = cyc;
        repeat (16) tick();
        check("s4_busy_before_to", {31'd0, busy}, 32'd1);
        check("s4_err_to_before", {31'd0, err_timeout}, 32'd0);
        tick();
        check("s4_err_to_set", {31'd0, err_timeout}, 32'd1);
        check("s4_busy_fell", {31'd0, busy}, 32'd0);
        check("s4_to_cycle", cyc - pe_cyc, 32'd17);
        repeat (3) tick();
        check("s4_err_to_sticky", {31'd0, err_timeout}, 32'd1);
        check("s4_no_done", done_cnt, 32'd0);
        set_dly(3, 3, 3, 3, 3, 3, 3, 3);
        push_pass(1'b1, 4'hF);
        push(K_D, 4'h1);
        do_start(8'd1, 4'hF, 1'b0);
        check("s4_err_to_cleared", {31'd0, err_timeout}, 32'd0);
        run_to_idle(200);
        check("s4_done_after_restart", done_cnt, 32'd1);

        // Rejected starts
        clr_counts();
        push(K_E, 4'h1);
        do_start(8'd0, 4'hF, 1'b0);
        check("s5_busy_passes0", {31'd0, busy}, 32'd0);
        push(K_E, 4'h1);
        do_start(8'd1, 4'h0, 1'b0);
        check("s5_busy_mask0", {31'd0, busy}, 32'd0);
        tick();
        check("s5_err_cfg_one_cycle", {31'd0, err_cfg}, 32'd0);
        check("s5_sb_drained", sb_q.size(), 32'd0);

        // Abort during writeback
        clr_counts();
        push_pass(1'b1, 4'hF);
        do_start(8'd1, 4'hF, 1'b0);
        wait_pe(50);
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("s6_busy_after_abort", {31'd0, busy}, 32'd0);
        repeat (20) tick();
        check("s6_no_done", done_cnt, 32'd0);
        check("s6_sb_drained", sb_q.size(), 32'd0);

        // Reset during WAIT_LOAD
        clr_counts();
        set_dly(0, 0, 0, 0, 3, 3, 3, 3);
        push(K_W, 4'hF);
        push(K_I, 4'hF);
        do_start(8'd2, 4'hF, 1'b0);
        repeat (3) tick();
        check("s7_busy_wait_load", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("s7_rst_busy", {31'd0, busy}, 32'd0);
        check("s7_rst_flags", {29'd0, done, err_cfg, err_timeout}, 32'd0);
        check("s7_rst_pulses", {20'd0, cif.load_spad_ctrl_wght, cif.load_spad_ctrl_iact, cif.pe_start}, 32'd0);
        check("s7_rst_pass_idx", {24'd0, pass_idx}, 32'd0);
        set_dly(3, 3, 3, 3, 3, 3, 3, 3);
        repeat (10) tick();
        check("s7_sb_drained", sb_q.size(), 32'd0);

        // start while busy is ignored
        clr_counts();
        push_pass(1'b1, 4'hF);
        push_pass(1'b1, 4'hF);
        push(K_D, 4'h1);
        do_start(8'd2, 4'hF, 1'b0);
        cfg_passes = 8'd0;
        for (int i = 0; i < 30; i++) begin
            start = (i % 3 == 0);
            tick();
        end
        start = 1'b0;
        run_to_idle(200);
        check("s8_done_cnt", done_cnt, 32'd1);
        check("s8_sb_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
